// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-ported memory between fetch and load/store
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ack_o,
  output logic                bus_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ready_i,
  output logic                stall_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_e;
  state_e             state_q;
  logic               last_d_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_we_q, if_ack_q, d_ack_q, bus_err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, if_rdata_q, d_rdata_q;
  logic [BE_W-1:0]    be_q;
  logic               if_elig, d_elig, pick_if, pick_d, timeout;
  // A port whose ack is showing this cycle is not eligible, so it cannot be re-granted on a stale req
  assign if_elig = if_req_i & ~if_ack_q;
  assign d_elig  = d_req_i & ~d_ack_q;
  assign pick_if = if_elig & (~d_elig | last_d_q);
  assign pick_d  = d_elig & ~pick_if;
  assign cnt_d   = cnt_q + 1'b1;
  assign timeout = cnt_d == CNT_W'(TIMEOUT);
  // Stall is forced low while in reset so it drops together with the acks
  assign stall_o = rst_ni & ((if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q));
  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign bus_err_o   = bus_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
  // Arbitration FSM: grant latches the request, BUSY waits for ready or timeout, then one-cycle ack
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b1;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_if | pick_d) begin
          state_q   <= pick_if ? IF_BUSY : D_BUSY;
          last_d_q  <= pick_d;
          cnt_q     <= '0;
          mem_req_q <= 1'b1;
          mem_we_q  <= pick_d & d_we_i;
          addr_q    <= pick_if ? if_addr_i : d_addr_i;
          wdata_q   <= pick_d & d_we_i ? d_wdata_i : '0;
          be_q      <= pick_d & d_we_i ? d_be_i : '1;
        end
        default: if (mem_ready_i | timeout) begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          bus_err_q <= ~mem_ready_i;
          if_ack_q  <= state_q == IF_BUSY;
          d_ack_q   <= state_q == D_BUSY;
          if (state_q == IF_BUSY) if_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
          else d_rdata_q <= mem_ready_i & ~mem_we_q ? mem_rdata_i : '0;
        end else cnt_q <= cnt_d;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int TO = 15;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0] d_be = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_ack, d_ack, bus_err, mem_req, mem_we, stall;
  logic [3:0] mem_be;
  int checks = 0, failures = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_be_i(d_be),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack), .bus_err_o(bus_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .stall_o(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: owner 0=none 1=fetch 2=data; prev is the last granted port
  int owner = 0, prev = 2, waited = 0, pick;
  logic wi, wd, done;
  logic [31:0] t_addr, t_wdata, rd;
  logic t_we;
  logic [3:0] t_be;
  logic e_ia = 0, e_da = 0, e_err = 0;
  logic [31:0] e_ird = 0, e_drd = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      owner = 0; prev = 2; waited = 0;
      e_ia = 0; e_da = 0; e_err = 0; e_ird = 0; e_drd = 0;
    end else begin
      wi = if_req && !e_ia;
      wd = d_req && !e_da;
      e_ia = 0; e_da = 0; e_err = 0;
      if (owner == 0) begin
        pick = (wi && wd) ? 3 - prev : wi ? 1 : wd ? 2 : 0;
        if (pick != 0) begin
          owner = pick; prev = pick; waited = 0;
          if (pick == 1) begin
            t_addr = if_addr; t_we = 0; t_wdata = 0; t_be = 4'hf;
          end else begin
            t_addr = d_addr; t_we = d_we; t_wdata = d_wdata; t_be = d_we ? d_be : 4'hf;
          end
        end
      end else begin
        done = mem_ready;
        if (!done) begin
          waited++;
          if (waited == TO) begin done = 1; e_err = 1; end
        end
        if (done) begin
          rd = (mem_ready && !t_we) ? mem_rdata : 32'h0;
          if (owner == 1) begin e_ia = 1; e_ird = rd; end
          else begin e_da = 1; e_drd = rd; end
          owner = 0;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_if_ack", if_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_stall", stall, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
    end else begin
      chk("m_if_ack", if_ack, e_ia);
      chk("m_d_ack", d_ack, e_da);
      chk("m_bus_err", bus_err, e_err);
      chk("m_mem_req", mem_req, owner != 0);
      chk("m_stall", stall, (if_req && !e_ia) || (d_req && !e_da));
      if (owner != 0) begin
        chk("m_mem_addr", mem_addr, t_addr);
        chk("m_mem_we", mem_we, t_we);
        chk("m_mem_be", mem_be, t_be);
        if (t_we) chk("m_mem_wdata", mem_wdata, t_wdata);
      end
      if (e_ia) chk("m_if_rdata", if_rdata, e_ird);
      if (e_da) chk("m_d_rdata", d_rdata, e_drd);
    end
  end

  task automatic drain();
    int n = 0;
    while ((if_req || d_req) && n < 60) begin
      cyc();
      n++;
      if (if_ack) if_req = 0;
      if (d_ack) d_req = 0;
    end
    chk("drain_bound", n < 60, 1);
    cyc();
  endtask

  initial begin
    mem_rdata = 32'h2004_0002;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    mem_ready = 1;
    // Tie from reset: fetch first, then data, then the next tie goes to fetch
    cyc(); if_req = 1; if_addr = 32'h0000_1000; d_req = 1; d_we = 0; d_addr = 32'h0000_2000;
    @(negedge clk); chk("t3_c0_mreq", mem_req, 0);
    cyc(); @(negedge clk); chk("t3_c1_addr", mem_addr, 32'h0000_1000); chk("t3_c1_we", mem_we, 0);
    cyc(); @(negedge clk); chk("t3_c2_if_ack", if_ack, 1); chk("t3_c2_mreq", mem_req, 0);
    cyc(); if_req = 0; @(negedge clk); chk("t3_c3_addr", mem_addr, 32'h0000_2000);
    cyc(); @(negedge clk); chk("t3_c4_d_ack", d_ack, 1); chk("t3_c4_rdata", d_rdata, 32'h2004_0002);
    cyc(); if_req = 1; d_req = 1;
    cyc(); @(negedge clk); chk("t3_tie_fetch", mem_addr, 32'h0000_1000);
    drain();
    // Fetch only, minimum latency
    cyc(); if_req = 1; if_addr = 32'h0040_0004;
    @(negedge clk); chk("t1_c0_stall", stall, 1); chk("t1_c0_mreq", mem_req, 0);
    cyc(); @(negedge clk);
    chk("t1_c1_mreq", mem_req, 1); chk("t1_c1_addr", mem_addr, 32'h0040_0004);
    chk("t1_c1_be", mem_be, 4'hf); chk("t1_c1_stall", stall, 1);
    cyc(); @(negedge clk);
    chk("t1_c2_ack", if_ack, 1); chk("t1_c2_rdata", if_rdata, 32'h2004_0002); chk("t1_c2_stall", stall, 0);
    cyc(); if_req = 0;
    cyc();
    // Store with partial byte enables
    cyc(); d_req = 1; d_we = 1; d_addr = 32'h1000_0010; d_wdata = 32'hCAFE_F00D; d_be = 4'b0011;
    cyc(); @(negedge clk);
    chk("t2_we", mem_we, 1); chk("t2_be", mem_be, 4'b0011);
    chk("t2_wdata", mem_wdata, 32'hCAFE_F00D); chk("t2_addr", mem_addr, 32'h1000_0010);
    cyc(); @(negedge clk); chk("t2_d_ack", d_ack, 1); chk("t2_rdata", d_rdata, 0);
    cyc(); d_req = 0;
    cyc();
    // Ready delayed: request held stable through five BUSY cycles
    mem_ready = 0;
    cyc(); if_req = 1; if_addr = 32'h0040_0100;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 2) if_addr = 32'hDEAD_0000;
      if (c == 5) mem_ready = 1;
      @(negedge clk); chk("t4_mreq", mem_req, 1); chk("t4_addr", mem_addr, 32'h0040_0100);
    end
    cyc(); if_req = 0;
    @(negedge clk); chk("t4_ack", if_ack, 1); chk("t4_err", bus_err, 0);
    cyc();
    // Timeout abort, then a normal access
    mem_ready = 0;
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h1000_0020;
    for (int c = 1; c <= TO; c++) begin
      cyc(); @(negedge clk); chk("t5_mreq", mem_req, 1); chk("t5_noack", d_ack, 0);
    end
    cyc(); d_req = 0;
    @(negedge clk);
    chk("t5_ack", d_ack, 1); chk("t5_err", bus_err, 1); chk("t5_rdata", d_rdata, 0); chk("t5_mreq_off", mem_req, 0);
    mem_ready = 1;
    cyc(); if_req = 1; if_addr = 32'h0040_0200;
    cyc(); @(negedge clk); chk("t5_next_mreq", mem_req, 1);
    cyc(); if_req = 0; @(negedge clk); chk("t5_next_ack", if_ack, 1); chk("t5_next_err", bus_err, 0);
    cyc();
    // Asynchronous reset in the middle of a data access
    mem_ready = 0;
    cyc(); d_req = 1; d_we = 1; d_addr = 32'h1000_0030; d_wdata = 32'h1234_5678; d_be = 4'hf;
    cyc(); @(negedge clk); chk("t6_busy", mem_req, 1);
    #2 rst_n = 0;
    #1 chk("t6_async_mreq", mem_req, 0); chk("t6_async_stall", stall, 0);
    chk("t6_async_dack", d_ack, 0); chk("t6_async_we", mem_we, 0);
    d_req = 0;
    repeat (2) @(posedge clk);
    cyc(); rst_n = 1; mem_ready = 1; if_req = 1; if_addr = 32'h0040_0300;
    cyc(); @(negedge clk); chk("t6_post_mreq", mem_req, 1);
    cyc(); if_req = 0; @(negedge clk); chk("t6_post_ack", if_ack, 1);
    cyc();
    // Random traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      mem_ready = ((i / 150) % 5 == 4) ? 1'b0 : ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      if (if_req && if_ack) begin if_req = 1'($urandom_range(0, 1)); if_addr = $urandom; end
      else if (!if_req) begin if_req = ($urandom_range(0, 2) == 0); if_addr = $urandom; end
      else if ($urandom_range(0, 19) == 0) if_addr = $urandom;
      else if ($urandom_range(0, 39) == 0) if_req = 0;
      if (d_req && d_ack) begin
        d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom; d_be = 4'($urandom);
      end else if (!d_req) begin
        d_req = ($urandom_range(0, 2) == 0); d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom; d_be = 4'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we;
      end else if ($urandom_range(0, 39) == 0) d_req = 0;
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
